risc_spm_ctrl_p: RTL

Parametrised multi-cycle control unit for the RISC stored-program machine datapath. It sequences fetch, decode and execute for a register file of 2^REG_AW general registers, and drives the Bus_1 and Bus_2 selects and all load, increment and write strobes. Compared with the fixed 4-register controller, it adds:
- OR, XOR and BRNZ opcodes;
- a correct not-taken branch skip;
- sticky illegal-opcode detection;
- single-step and halt-resume control.

---
 rtl/risc_spm_ctrl_p.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/risc_spm_ctrl_p.sv
`default_nettype none
// ============================================================================
//  Module   : risc_spm_ctrl_p
//  Purpose  : Parametrised multi-cycle fetch/decode/execute controller for the
//             RISC stored-program machine datapath, with OR/XOR/BRNZ opcodes,
//             not-taken branch skip, sticky illegal-opcode flag and
//             single-step / halt-resume control.
//  Revision : 1.0  initial release
// ============================================================================
module risc_spm_ctrl_p #(
    parameter int WORD_W = 8,
    parameter int REG_AW = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_W-1:0]      instruction,
    input  logic                   Zflag,
    input  logic                   step_mode,
    input  logic                   resume,
    output logic [(1<<REG_AW)-1:0] Load_R,
    output logic                   Load_PC,
    output logic                   Inc_PC,
    output logic                   Load_IR,
    output logic                   Load_Add_R,
    output logic                   Load_Reg_Y,
    output logic                   Load_Reg_Z,
    output logic                   write,
    output logic [REG_AW:0]        Sel_Bus_1_Mux,
    output logic [1:0]             Sel_Bus_2_Mux,
    output logic                   halted,
    output logic                   err
);

    localparam int             NREG      = 1 << REG_AW;
    localparam logic [REG_AW:0] C_SEL1_PC = (REG_AW+1)'(NREG);

    localparam logic [1:0] C_SEL2_ALU  = 2'd0;
    localparam logic [1:0] C_SEL2_BUS1 = 2'd1;
    localparam logic [1:0] C_SEL2_MEM  = 2'd2;

    localparam logic [3:0] C_OP_NOP  = 4'h0;
    localparam logic [3:0] C_OP_ADD  = 4'h1;
    localparam logic [3:0] C_OP_SUB  = 4'h2;
    localparam logic [3:0] C_OP_AND  = 4'h3;
    localparam logic [3:0] C_OP_NOT  = 4'h4;
    localparam logic [3:0] C_OP_RD   = 4'h5;
    localparam logic [3:0] C_OP_WR   = 4'h6;
    localparam logic [3:0] C_OP_BR   = 4'h7;
    localparam logic [3:0] C_OP_BRZ  = 4'h8;
    localparam logic [3:0] C_OP_OR   = 4'h9;
    localparam logic [3:0] C_OP_XOR  = 4'hA;
    localparam logic [3:0] C_OP_BRNZ = 4'hB;
    localparam logic [3:0] C_OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EXE  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    state_t state_q, state_d;
    logic   err_q, err_d;

    logic [3:0]        w_opcode;
    logic [REG_AW-1:0] w_dst;
    logic [REG_AW-1:0] w_src;
    logic              w_taken;
    state_t            w_end_state;

    assign w_opcode    = instruction[WORD_W-1 -: 4];
    assign w_dst       = instruction[2*REG_AW-1 -: REG_AW];
    assign w_src       = instruction[REG_AW-1:0];
    // Conditional branches: BRZ on Z set, BRNZ on Z clear.
    assign w_taken     = ((w_opcode == C_OP_BRZ)  &&  Zflag) ||
                         ((w_opcode == C_OP_BRNZ) && !Zflag);
    // Where every instruction goes once it completes.
    assign w_end_state = step_mode ? S_HALT : S_FET1;
    assign err         = err_q;

    // State and sticky error register; reset forces IDLE immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath strobes, decoded from state, opcode and Zflag.
    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        Load_R        = '0;
        Load_PC       = 1'b0;
        Inc_PC        = 1'b0;
        Load_IR       = 1'b0;
        Load_Add_R    = 1'b0;
        Load_Reg_Y    = 1'b0;
        Load_Reg_Z    = 1'b0;
        write         = 1'b0;
        Sel_Bus_1_Mux = '0;
        Sel_Bus_2_Mux = C_SEL2_ALU;
        halted        = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FET1;
            S_FET1: begin
                Sel_Bus_1_Mux = C_SEL1_PC;
                Sel_Bus_2_Mux = C_SEL2_BUS1;
                Load_Add_R    = 1'b1;
                state_d       = S_FET2;
            end
            S_FET2: begin
                Sel_Bus_2_Mux = C_SEL2_MEM;
                Load_IR       = 1'b1;
                Inc_PC        = 1'b1;
                state_d       = S_DEC;
            end
            S_DEC: begin
                case (w_opcode)
                    C_OP_NOP: state_d = w_end_state;
                    C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR, C_OP_XOR: begin
                        Sel_Bus_1_Mux = {1'b0, w_src};
                        Sel_Bus_2_Mux = C_SEL2_BUS1;
                        Load_Reg_Y    = 1'b1;
                        state_d       = S_EXE;
                    end
                    C_OP_NOT: begin
                        Sel_Bus_1_Mux = {1'b0, w_src};
                        Sel_Bus_2_Mux = C_SEL2_ALU;
                        Load_Reg_Z    = 1'b1;
                        Load_R[w_dst] = 1'b1;
                        state_d       = w_end_state;
                    end
                    C_OP_RD, C_OP_WR, C_OP_BR: begin
                        Sel_Bus_1_Mux = C_SEL1_PC;
                        Sel_Bus_2_Mux = C_SEL2_BUS1;
                        Load_Add_R    = 1'b1;
                        state_d       = (w_opcode == C_OP_RD) ? S_RD1 :
                                        (w_opcode == C_OP_WR) ? S_WR1 : S_BR1;
                    end
                    C_OP_BRZ, C_OP_BRNZ: begin
                        if (w_taken) begin
                            Sel_Bus_1_Mux = C_SEL1_PC;
                            Sel_Bus_2_Mux = C_SEL2_BUS1;
                            Load_Add_R    = 1'b1;
                            state_d       = S_BR1;
                        end else begin
                            // Step the PC over the unused target address word.
                            Inc_PC  = 1'b1;
                            state_d = w_end_state;
                        end
                    end
                    C_OP_HALT: state_d = S_HALT;
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_EXE: begin
                Sel_Bus_1_Mux = {1'b0, w_dst};
                Sel_Bus_2_Mux = C_SEL2_ALU;
                Load_Reg_Z    = 1'b1;
                Load_R[w_dst] = 1'b1;
                state_d       = w_end_state;
            end
            S_RD1, S_WR1: begin
                Sel_Bus_2_Mux = C_SEL2_MEM;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
                state_d       = (state_q == S_RD1) ? S_RD2 : S_WR2;
            end
            S_RD2: begin
                Sel_Bus_2_Mux = C_SEL2_MEM;
                Load_R[w_dst] = 1'b1;
                state_d       = w_end_state;
            end
            S_WR2: begin
                Sel_Bus_1_Mux = {1'b0, w_src};
                write         = 1'b1;
                state_d       = w_end_state;
            end
            S_BR1: begin
                Sel_Bus_2_Mux = C_SEL2_MEM;
                Load_Add_R    = 1'b1;
                state_d       = S_BR2;
            end
            S_BR2: begin
                Sel_Bus_2_Mux = C_SEL2_MEM;
                Load_PC       = 1'b1;
                state_d       = w_end_state;
            end
            S_HALT: begin
                halted = 1'b1;
                // An illegal opcode can only be cleared by reset.
                if (resume && !err_q) state_d = S_FET1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
